input_port_ctrl: RTL

- Per-port input stage of the mesh router. It sits between one incoming link (or the local PE injection port) and the per-VC switch arbiters.
- Holds one single-slot buffer per virtual channel: even VC0 and odd VC1.
- Accepts packets from the link with a send/ready handshake and presents them as valid/data to the arbiter of the matching VC. It frees a slot when that arbiter returns a clear.
- Router top instantiates five copies: up, down, left, right, pe.

---
 rtl/input_port_ctrl_pkg.sv | 35 +++
 rtl/input_port_ctrl_vc_slot_buffer.sv | 53 +++++
 rtl/input_port_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/input_port_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// input_port_ctrl_pkg
//   Shared router definitions used by the input port stage and its slot
//   buffers. It holds the packet field layout, the router port indices and
//   the slot state encoding.
// ----------------------------------------------------------------------------
package input_port_ctrl_pkg;

  // Packet layout
  localparam int DATA_W    = 64;
  localparam int VC_BIT    = 63;  // virtual-channel tag: 0 = VC0 (even), 1 = VC1 (odd)
  localparam int DIR_X_BIT = 62;
  localparam int DIR_Y_BIT = 61;
  localparam int HOP_X_MSB = 55;
  localparam int HOP_X_LSB = 52;
  localparam int HOP_Y_MSB = 51;
  localparam int HOP_Y_LSB = 48;

  // Counter width for the received/error statistics
  localparam int CNT_W = 16;

  // Router port indices, one input_port_ctrl instance per port
  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int PE    = 4;

  // Occupancy of a single-slot VC buffer
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : input_port_ctrl_pkg

// File: rtl/input_port_ctrl_vc_slot_buffer.sv
// ----------------------------------------------------------------------------
// vc_slot_buffer
//   One-packet buffer for a single virtual channel, with its full flag.
//   If a write and a clear arrive on the same edge, the write wins: the slot
//   stays full and takes the new data. A clear leaves the data in place.
//
// Ports
//   clk        router clock
//   reset      synchronous, active-high reset
//   wr_en_i    store wr_data_i and mark the slot full
//   wr_data_i  packet to store
//   clr_i      downstream arbiter took the packet; mark the slot empty
//   full_o     slot holds a packet (registered)
//   data_o     slot contents (registered)
// ----------------------------------------------------------------------------
module vc_slot_buffer
  import input_port_ctrl_pkg::*;
#(
  parameter int DATA_W = input_port_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop in the block samples pre-edge values no matter how statements are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      // NOTE: the data register is reset as well, because downstream logic
      // sees the data bus directly and expects zeros after reset.
      data_q  <= '0;
    end else if (wr_en_i) begin
      state_q <= SLOT_FULL;
      data_q  <= wr_data_i;
    end else if (clr_i) begin
      // A clear on an already empty slot changes nothing. The data is kept.
      state_q <= SLOT_EMPTY;
    end
  end

  assign full_o = (state_q == SLOT_FULL);
  assign data_o = data_q;

endmodule : vc_slot_buffer

// File: rtl/input_port_ctrl.sv
// ----------------------------------------------------------------------------
// input_port_ctrl
//   Per-port input stage of the mesh router. It accepts packets from one link
//   through a send/ready handshake and parks each packet in a single-slot
//   buffer for its virtual channel. The packet is presented to that VC's
//   switch arbiter until the arbiter clears it. Each cycle the router-wide
//   polarity bit opens one VC to the link while the other VC is served
//   internally.
//
// Ports
//   clk                 router clock
//   reset               synchronous, active-high reset
//   polarity            phase bit: 0 -> link may fill VC1, 1 -> link may fill VC0
//   si / di / ri        link send strobe, packet, ready (ri is combinational)
//   vc0_valid/_data     VC0 buffer state toward the even arbiter
//   vc0_clear           even arbiter took the VC0 packet
//   vc1_valid/_data     VC1 buffer state toward the odd arbiter
//   vc1_clear           odd arbiter took the VC1 packet
//   rx_count            accepted packets, saturating
//   err_count           dropped packets (wrong phase or overrun), saturating
// ----------------------------------------------------------------------------
module input_port_ctrl
  import input_port_ctrl_pkg::*;
#(
  parameter int DATA_W = input_port_ctrl_pkg::DATA_W,
  parameter int VC_BIT = input_port_ctrl_pkg::VC_BIT,
  parameter int CNT_W  = input_port_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              si,
  input  logic [DATA_W-1:0] di,
  output logic              ri,
  output logic              vc0_valid,
  output logic [DATA_W-1:0] vc0_data,
  input  logic              vc0_clear,
  output logic              vc1_valid,
  output logic [DATA_W-1:0] vc1_data,
  input  logic              vc1_clear,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  err_count
);

  logic ext_vc;     // VC currently open to the link
  logic ext_full;
  logic full0;
  logic full1;
  logic accept;
  logic drop;
  logic wr0;
  logic wr1;

  assign ext_vc   = ~polarity;
  assign ext_full = ext_vc ? full1 : full0;

  // The upstream sender samples ri in the same cycle it raises si, so ri must
  // stay combinational on the current full flag.
  assign ri = ~ext_full;

  // A packet is taken only when the link VC has room and the packet is tagged
  // for the VC that is open this phase. Any other send is dropped.
  assign accept = si & ri & (di[VC_BIT] == ext_vc);
  assign drop   = si & ~accept;

  assign wr0 = accept & ~ext_vc;
  assign wr1 = accept &  ext_vc;

  vc_slot_buffer #(.DATA_W(DATA_W)) u_vc0 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr0),
    .wr_data_i (di),
    .clr_i     (vc0_clear),
    .full_o    (full0),
    .data_o    (vc0_data)
  );

  vc_slot_buffer #(.DATA_W(DATA_W)) u_vc1 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr1),
    .wr_data_i (di),
    .clr_i     (vc1_clear),
    .full_o    (full1),
    .data_o    (vc1_data)
  );

  assign vc0_valid = full0;
  assign vc1_valid = full1;

  // Saturating statistics counters
  logic [CNT_W-1:0] rx_cnt_q,  rx_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept && !(&rx_cnt_q)) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end
    if (drop && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rx_count  = rx_cnt_q;
  assign err_count = err_cnt_q;

endmodule : input_port_ctrl
